// File: rtl/plasticity_event_scheduler.sv
// Reward-event FIFO feeding a plasticity controller one update at a time,
// with busy-acknowledge timeout, post-update cooldown and drop/lost counters.
module plasticity_event_scheduler #(
    parameter int unsigned DIM          = 16384,
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned COOLDOWN     = 16,
    parameter int unsigned BUSY_TIMEOUT = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_evt_valid,
    output logic                   o_evt_ready,
    input  logic signed [7:0]      i_evt_reward,
    input  logic [DIM-1:0]         i_evt_context,
    output logic                   o_trigger,
    output logic signed [7:0]      o_reward,
    output logic [DIM-1:0]         o_context_hv,
    input  logic                   i_ctrl_busy,
    input  logic                   i_ctrl_done,
    output logic [$clog2(DEPTH):0] o_queue_level,
    output logic [15:0]            o_drop_count,
    output logic [15:0]            o_lost_count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = PW + 1;
    localparam int unsigned TW = $clog2(BUSY_TIMEOUT + 1) + 1;
    localparam int unsigned CW = $clog2(COOLDOWN + 1) + 1;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_ISSUE     = 3'd1;
    localparam logic [2:0] S_WAIT_BUSY = 3'd2;
    localparam logic [2:0] S_WAIT_DONE = 3'd3;
    localparam logic [2:0] S_COOLDOWN  = 3'd4;

    logic signed [7:0] rew_mem [DEPTH];
    logic [DIM-1:0]    ctx_mem [DEPTH];

    logic [2:0]        state_q, state_d;
    logic [LW-1:0]     count_q, count_d;
    logic [PW-1:0]     wr_q, rd_q;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic [CW-1:0]     cd_q, cd_d;
    logic [15:0]       drop_q, drop_d;
    logic [15:0]       lost_q, lost_d;
    logic signed [7:0] rew_q;
    logic [DIM-1:0]    ctx_q;
    logic              accept, push, pop;

    // Ready comes from the registered level only, so a same-cycle pop never frees a slot early.
    assign o_evt_ready   = count_q < LW'(DEPTH);
    assign accept        = i_evt_valid && o_evt_ready;
    assign push          = accept && (i_evt_reward != 8'sd0);
    assign count_d       = count_q + LW'(push) - LW'(pop);
    assign drop_d        = (accept && !push && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;

    assign o_trigger     = (state_q == S_ISSUE);
    assign o_reward      = rew_q;
    assign o_context_hv  = ctx_q;
    assign o_queue_level = count_q;
    assign o_drop_count  = drop_q;
    assign o_lost_count  = lost_q;

    always_comb begin
        state_d = state_q;
        tmo_d   = tmo_q;
        cd_d    = cd_q;
        lost_d  = lost_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (count_q != '0 && !i_ctrl_busy) begin
                    pop     = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                tmo_d   = '0;
                state_d = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (i_ctrl_busy) begin
                    state_d = S_WAIT_DONE;
                end else if (32'(tmo_q) + 32'd1 >= BUSY_TIMEOUT) begin
                    if (lost_q != 16'hFFFF) lost_d = lost_q + 16'd1;
                    cd_d    = '0;
                    state_d = S_COOLDOWN;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_WAIT_DONE: begin
                if (i_ctrl_done) begin
                    cd_d    = '0;
                    state_d = S_COOLDOWN;
                end
            end
            S_COOLDOWN: begin
                if (32'(cd_q) + 32'd1 >= COOLDOWN) state_d = S_IDLE;
                else cd_d = cd_q + CW'(1);
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            rew_mem[wr_q] <= i_evt_reward;
            ctx_mem[wr_q] <= i_evt_context;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            count_q <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            tmo_q   <= '0;
            cd_q    <= '0;
            drop_q  <= '0;
            lost_q  <= '0;
            rew_q   <= '0;
            ctx_q   <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            tmo_q   <= tmo_d;
            cd_q    <= cd_d;
            drop_q  <= drop_d;
            lost_q  <= lost_d;
            if (push) wr_q <= wr_q + PW'(1);
            if (pop) begin
                rd_q  <= rd_q + PW'(1);
                rew_q <= rew_mem[rd_q];
                ctx_q <= ctx_mem[rd_q];
            end
        end
    end

endmodule

// File: tb/tb_plasticity_event_scheduler.sv
// Randomized bench for plasticity_event_scheduler against a timestamp-based
// reference model of queue contents, issue times, cooldown and counters.
module tb_plasticity_event_scheduler;

    localparam int DIM   = 64;
    localparam int DEPTH = 4;
    localparam int CD    = 16;
    localparam int BT    = 8;
    localparam int CD1   = (CD < 1) ? 1 : CD;

    typedef struct packed {
        logic [7:0]     r;
        logic [DIM-1:0] c;
    } ev_t;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    evt_valid;
    logic                    evt_ready;
    logic signed [7:0]       evt_reward;
    logic [DIM-1:0]          evt_context;
    logic                    trigger;
    logic signed [7:0]       reward;
    logic [DIM-1:0]          context_hv;
    logic                    busy;
    logic                    done;
    logic [$clog2(DEPTH):0]  level;
    logic [15:0]             drop_count;
    logic [15:0]             lost_count;

    always #5 clk = ~clk;

    plasticity_event_scheduler #(
        .DIM(DIM), .DEPTH(DEPTH), .COOLDOWN(CD), .BUSY_TIMEOUT(BT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .i_evt_valid(evt_valid),
        .o_evt_ready(evt_ready),
        .i_evt_reward(evt_reward),
        .i_evt_context(evt_context),
        .o_trigger(trigger),
        .o_reward(reward),
        .o_context_hv(context_hv),
        .i_ctrl_busy(busy),
        .i_ctrl_done(done),
        .o_queue_level(level),
        .o_drop_count(drop_count),
        .o_lost_count(lost_count)
    );

    int n_chk = 0;
    int n_pass = 0;

    // reference model state
    ev_t    mq[$];
    ev_t    hold;
    longint cyc = 0;
    longint trig_cycle, free_at, last_trig;
    bit     wb, wd, mvalid, acc_last;
    int     m_drop, m_lost, ntrig;
    logic [7:0] trig_log[$];

    // controller stimulus
    bit     hold_busy, spur, rand_ctl;
    int     ctl_never, ctl_bd, ctl_dd;
    longint bz_start, bz_end;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic logic [7:0] rnd_rew();
        logic [7:0] v;
        v = 8'($urandom);
        if (v == 8'd0) v = 8'd1;
        return v;
    endfunction

    task automatic model_update();
        bit idle, rdy;
        if (rst) begin
            mq.delete();
            hold = '0;
            wb = 0; wd = 0;
            free_at = 0; trig_cycle = -1; last_trig = -1;
            m_drop = 0; m_lost = 0;
            bz_start = 1; bz_end = 0;
            acc_last = 0;
            mvalid = 1;
            return;
        end
        idle = !wb && !wd && cyc >= free_at;
        rdy = mq.size() < DEPTH;
        acc_last = evt_valid && rdy;
        if (wb && cyc > trig_cycle) begin
            if (busy) begin
                wb = 0; wd = 1;
            end else if (cyc - trig_cycle >= BT) begin
                wb = 0;
                if (m_lost < 16'hFFFF) m_lost++;
                free_at = cyc + 1 + CD1;
            end
        end else if (wd) begin
            if (done) begin
                wd = 0;
                free_at = cyc + 1 + CD1;
            end
        end
        if (idle && mq.size() > 0 && !busy) begin
            hold = mq.pop_front();
            trig_cycle = cyc + 1;
            wb = 1;
            if (rand_ctl) begin
                ctl_never = ($urandom_range(0, 9) == 0);
                ctl_bd = $urandom_range(1, 10);
                ctl_dd = $urandom_range(1, 8);
            end
            if (ctl_never != 0) begin
                bz_start = 1; bz_end = 0;
            end else begin
                bz_start = trig_cycle + ctl_bd;
                bz_end = bz_start + ctl_dd;
            end
        end
        if (acc_last) begin
            if (evt_reward == 8'sd0) begin
                if (m_drop < 16'hFFFF) m_drop++;
            end else begin
                mq.push_back({evt_reward, evt_context});
            end
        end
    endtask

    task automatic tick();
        busy = hold_busy || (cyc >= bz_start && cyc <= bz_end);
        done = (cyc == bz_end) || spur;
        if (mvalid) begin
            chk("level", level, mq.size());
            chk("ready", evt_ready, mq.size() < DEPTH);
            chk("trigger", trigger, trig_cycle == cyc);
            chk("reward", $unsigned(reward), hold.r);
            chk("context", context_hv, hold.c);
            chk("drop", drop_count, m_drop);
            chk("lost", lost_count, m_lost);
            if (trigger === 1'b1) begin
                if (last_trig >= 0)
                    chk("trig_gap", (cyc - last_trig) >= 3 + CD, 1);
                last_trig = cyc;
                ntrig++;
                trig_log.push_back($unsigned(reward));
            end
        end
        @(posedge clk);
        model_update();
        @(negedge clk);
        cyc++;
    endtask

    task automatic send(input logic [7:0] r, input logic [DIM-1:0] c);
        int k;
        evt_valid = 1'b1;
        evt_reward = r;
        evt_context = c;
        k = 0;
        acc_last = 0;
        while (!acc_last && k < 200) begin
            tick();
            k++;
        end
        chk("send_accept", acc_last, 1);
        evt_valid = 1'b0;
    endtask

    initial begin
        int t0, k;
        logic [DIM-1:0] ctx_a;
        logic [7:0] exp_r[3];

        rst = 1'b1; evt_valid = 1'b0; evt_reward = '0; evt_context = '0;
        busy = 1'b0; done = 1'b0; hold_busy = 0; spur = 0; rand_ctl = 0;
        ctl_never = 0; ctl_bd = 2; ctl_dd = 10;
        bz_start = 1; bz_end = 0; mvalid = 0; ntrig = 0;
        trig_cycle = -1; last_trig = -1; free_at = 0;
        tick();
        tick();
        rst = 1'b0;

        // single event, busy 2 cycles after trigger, done 10 later
        ctx_a = {$urandom, $urandom};
        t0 = ntrig;
        send(8'sd5, ctx_a);
        repeat (40) tick();
        chk("r019_trigs", ntrig - t0, 1);

        // zero-reward event is dropped
        t0 = ntrig;
        send(8'd0, {$urandom, $urandom});
        repeat (30) tick();
        chk("r021_trigs", ntrig - t0, 0);
        chk("r021_drop", drop_count, 1);

        // fill to DEPTH while busy blocks issue; fifth waits
        hold_busy = 1;
        for (int i = 0; i < 4; i++) send(rnd_rew(), {$urandom, $urandom});
        evt_valid = 1'b1;
        evt_reward = rnd_rew();
        evt_context = {$urandom, $urandom};
        repeat (6) tick();
        chk("r020_level", level, 4);
        chk("r020_ready", evt_ready, 0);
        hold_busy = 0;
        send(evt_reward, evt_context);
        repeat (180) tick();

        // controller never acknowledges
        ctl_never = 1;
        send(rnd_rew(), {$urandom, $urandom});
        send(rnd_rew(), {$urandom, $urandom});
        repeat (12) tick();
        chk("r022_lost1", lost_count, 1);
        repeat (50) tick();
        chk("r022_lost2", lost_count, 2);
        ctl_never = 0;

        // three back-to-back events in FIFO order
        ctl_bd = 1; ctl_dd = 3;
        trig_log.delete();
        for (int i = 0; i < 3; i++) begin
            exp_r[i] = rnd_rew();
            send(exp_r[i], {$urandom, $urandom});
        end
        repeat (90) tick();
        chk("r023_count", trig_log.size(), 3);
        for (int i = 0; i < 3; i++)
            chk("r023_order", (trig_log.size() > i) ? trig_log[i] : 8'hxx, exp_r[i]);

        // reset mid-update with two events queued
        ctl_bd = 2; ctl_dd = 25;
        for (int i = 0; i < 3; i++) send(rnd_rew(), {$urandom, $urandom});
        k = 0;
        while (!wd && k < 30) begin
            tick();
            k++;
        end
        chk("r024_reach", wd, 1);
        chk("r024_queued", level, 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        t0 = ntrig;
        for (int i = 0; i < 40; i++) begin
            spur = ($urandom_range(0, 2) == 0);
            tick();
        end
        spur = 0;
        chk("r024_trigs", ntrig - t0, 0);

        // randomized traffic
        rand_ctl = 1;
        for (int i = 0; i < 1500; i++) begin
            evt_valid = ($urandom_range(0, 2) == 0);
            evt_reward = ($urandom_range(0, 4) == 0) ? 8'd0 : rnd_rew();
            evt_context = {$urandom, $urandom};
            spur = ($urandom_range(0, 19) == 0);
            rst = ($urandom_range(0, 399) == 0);
            tick();
        end
        evt_valid = 1'b0; spur = 0; rst = 1'b0;
        repeat (150) tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/plasticity_event_scheduler.md
PLASTICITY_EVENT_SCHEDULER -- requirements
Module: plasticity_event_scheduler

Interface
REQ-001 Parameters SHALL be: DIM, default 16384, context HV width; DEPTH, default 4, event queue entries (power of two, >=2); COOLDOWN, default 16, idle cycles between updates (0 = none); BUSY_TIMEOUT, default 8, cycles allowed for controller busy to rise.
REQ-002 Ports SHALL be, in order:
  clk  in  1  sole clock, all logic on rising edge;
  rst  in  1  synchronous reset, active-high;
  i_evt_valid  in  1  reward event offered;
  o_evt_ready  out  1  queue can accept an event;
  i_evt_reward  in  8 signed  event reward;
  i_evt_context  in  DIM  event context HV;
  o_trigger  out  1  one-cycle start pulse to plasticity controller;
  o_reward  out  8 signed  reward presented to controller;
  o_context_hv  out  DIM  context presented to controller;
  i_ctrl_busy  in  1  controller update in progress;
  i_ctrl_done  in  1  controller one-cycle completion pulse;
  o_queue_level  out  $clog2(DEPTH)+1  queued event count;
  o_drop_count  out  16  zero-reward events discarded;
  o_lost_count  out  16  triggers not acknowledged by busy.

Function
REQ-003 An event SHALL be accepted on a cycle with i_evt_valid && o_evt_ready.
REQ-004 o_evt_ready SHALL be registered-count based: high iff o_queue_level < DEPTH; a pop on the same cycle SHALL NOT raise ready that cycle.
REQ-005 Accepted events with i_evt_reward == 0 SHALL NOT be enqueued; o_drop_count SHALL increment, saturating at 16'hFFFF.
REQ-006 Queue SHALL be FIFO with wrap-around read/write pointers; push and pop in the same cycle SHALL leave o_queue_level unchanged.
REQ-007 FSM states SHALL be S_IDLE, S_ISSUE, S_WAIT_BUSY, S_WAIT_DONE, S_COOLDOWN.
REQ-008 S_IDLE: if queue non-empty and i_ctrl_busy low, pop head into hold registers o_reward/o_context_hv and go to S_ISSUE; otherwise stay.
REQ-009 S_ISSUE: o_trigger high for exactly this one cycle; next state S_WAIT_BUSY with timeout counter cleared.
REQ-010 S_WAIT_BUSY: i_ctrl_busy high -> S_WAIT_DONE; else increment counter; after BUSY_TIMEOUT cycles without busy, increment o_lost_count (saturating) and go to S_COOLDOWN.
REQ-011 S_WAIT_DONE: stay until i_ctrl_done high, then S_COOLDOWN; no timeout.
REQ-012 S_COOLDOWN: wait COOLDOWN cycles then S_IDLE; COOLDOWN == 0 SHALL go to S_IDLE on the next cycle.
REQ-013 o_reward and o_context_hv SHALL remain constant from the pop cycle until the next pop; they SHALL NOT track queue or input changes.
REQ-014 i_ctrl_done outside S_WAIT_DONE SHALL be ignored.
REQ-015 Trigger-to-trigger spacing SHALL be at least 3 + COOLDOWN cycles.
REQ-016 Enqueue SHALL proceed in every state, independent of FSM activity.

Reset
REQ-017 On rst high at a clock edge: state S_IDLE, queue empty, o_queue_level 0, o_evt_ready 1, o_trigger 0, o_reward 0, o_context_hv 0, both counters 0, timeout/cooldown counters 0.
REQ-018 Reset asserted mid-update SHALL abandon the in-flight event and all queued events; no o_trigger SHALL be issued until a new event is accepted after rst deasserts.

Verification
REQ-019 Single event reward=+5, context=A, controller model busy 2 cycles after trigger, done 10 cycles later -> one o_trigger pulse, o_reward=+5, o_context_hv=A stable until done, level 1->0.
REQ-020 Push 5 events with DEPTH=4 and controller busy held high -> 4 accepted, o_evt_ready low with level 4; 5th held off until the first pop.
REQ-021 Event reward=0 -> no enqueue, o_drop_count=1, no trigger.
REQ-022 Controller never asserts busy -> o_lost_count=1 after BUSY_TIMEOUT=8 cycles, then COOLDOWN, then next queued event is issued.
REQ-023 Three back-to-back events, COOLDOWN=16 -> triggers issued in FIFO order with rewards matching inputs, each gap >= 3+16 cycles after done.
REQ-024 rst pulsed in S_WAIT_DONE with 2 events queued -> all outputs at reset values, no further trigger, spurious i_ctrl_done ignored.
